// File: rtl/pc_step_sequencer.sv
// pc_step_sequencer
//   Program-counter sequencer for the fetch path. Holds the PC and advances it
//   by STEP (a power of two) on each accepted fetch handshake. Redirects
//   (branch/jump) and halt requests are also handled here. An increment that
//   overflows WIDTH bits wraps to zero and sets a sticky wrap flag. With
//   WRAP_STOP=1 the overflow also halts the sequencer until a redirect.
// Ports
//   clk_i            clock, rising edge
//   rst_ni           asynchronous active-low reset
//   pc_ready_i       fetch stage accepts pc_o this cycle
//   halt_req_i       level request to stop issuing PCs
//   redirect_valid_i branch/jump target present this cycle
//   redirect_addr_i  branch/jump target (low log2(STEP) bits ignored)
//   pc_o             current PC (registered)
//   pc_valid_o       pc_o is offered to fetch (state RUN)
//   pc_plus_o        pc_o + STEP modulo 2**WIDTH
//   wrap_flag_o      sticky overflow flag, cleared by redirect or reset
//   halted_o         sequencer is in HALT
module pc_step_sequencer #(
    parameter int unsigned      WIDTH     = 32,
    parameter int unsigned      STEP      = 4,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter bit               WRAP_STOP = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             pc_ready_i,
    input  logic             halt_req_i,
    input  logic             redirect_valid_i,
    input  logic [WIDTH-1:0] redirect_addr_i,
    output logic [WIDTH-1:0] pc_o,
    output logic             pc_valid_o,
    output logic [WIDTH-1:0] pc_plus_o,
    output logic             wrap_flag_o,
    output logic             halted_o
);

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_e;

    localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'(STEP - 1);
    localparam logic [WIDTH:0]   STEP_EXT = (WIDTH+1)'(STEP);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             wrap_q, wrap_d;
    // Set when HALT was entered because of an overflow; such a halt is left
    // only through a redirect, never by halt_req dropping.
    logic             wstop_q, wstop_d;
    logic [WIDTH:0]   sum;
    logic             ovf;
    logic             xfer;

    // STEP is a power of two, so adding it never disturbs the bits below
    // log2(STEP); the extra top bit is the carry-out of bit WIDTH-1.
    assign sum  = {1'b0, pc_q} + STEP_EXT;
    assign ovf  = sum[WIDTH];
    assign xfer = (state_q == RUN) && pc_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= BOOT;
            pc_q    <= RESET_VEC;
            wrap_q  <= 1'b0;
            wstop_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            wrap_q  <= wrap_d;
            wstop_q <= wstop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        wrap_d  = wrap_q;
        wstop_d = wstop_q;
        // A redirect wins over both transfer and halt_req; the offered pc is
        // treated as consumed without incrementing.
        if (redirect_valid_i && state_q != BOOT) begin
            state_d = RUN;
            pc_d    = redirect_addr_i & ~LOW_MASK;
            wrap_d  = 1'b0;
            wstop_d = 1'b0;
        end else begin
            case (state_q)
                BOOT: state_d = RUN;
                RUN: begin
                    if (xfer) begin
                        pc_d = sum[WIDTH-1:0];
                        if (ovf) begin
                            wrap_d = 1'b1;
                            if (WRAP_STOP) begin
                                state_d = HALT;
                                wstop_d = 1'b1;
                            end
                        end
                    end
                    if (halt_req_i) state_d = HALT;
                end
                HALT: begin
                    if (!wstop_q && !halt_req_i) state_d = RUN;
                end
                default: state_d = BOOT;
            endcase
        end
    end

    always_comb begin
        pc_o        = pc_q;
        pc_plus_o   = sum[WIDTH-1:0];
        wrap_flag_o = wrap_q;
        pc_valid_o  = (state_q == RUN);
        halted_o    = (state_q == HALT);
    end

endmodule
